// File: rtl/uart_pkg.sv
// Shared framing constants, FSM encodings and sizing helper for the uart transceiver.
package uart_pkg;

   localparam logic StartBit  = 1'b0;
   localparam logic StopBit   = 1'b1;
   localparam logic IdleLevel = 1'b1;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} txState_t;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rxState_t;

   // Bits needed to count 0..n-1; never below 1 so counters stay legal vectors.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while (w < 32 && (32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// Receive half of the uart: two-flop input synchronizer, centre-sampling receive FSM
// and the valid/ready output holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned Divisor = 1736,
   parameter int unsigned Width   = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             SIn,
   output logic [Width-1:0] DataOut,
   output logic             DataOutValid,
   input  logic             DataOutReady
);

   localparam int unsigned     CntW    = clog2(Divisor);
   localparam int unsigned     BitW    = clog2(Width);
   localparam logic [CntW-1:0] BitEnd  = CntW'(Divisor - 1);
   localparam logic [CntW-1:0] HalfEnd = CntW'(Divisor / 2 - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(Width - 1);

   logic [1:0]       sync;
   logic             rxIn;
   rxState_t         state, stateNext;
   logic [CntW-1:0]  cnt, cntNext;
   logic [BitW-1:0]  bitIdx, bitIdxNext;
   logic [Width-1:0] shift, shiftNext, dataNext;
   logic             validNext;

   assign rxIn = sync[1];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync         <= {2{IdleLevel}};
         state        <= RxIdle;
         cnt          <= '0;
         bitIdx       <= '0;
         shift        <= '0;
         DataOut      <= '0;
         DataOutValid <= 1'b0;
      end else begin
         sync         <= {sync[0], SIn};
         state        <= stateNext;
         cnt          <= cntNext;
         bitIdx       <= bitIdxNext;
         shift        <= shiftNext;
         DataOut      <= dataNext;
         DataOutValid <= validNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitIdxNext = bitIdx;
      shiftNext  = shift;
      dataNext   = DataOut;
      validNext  = DataOutValid && !DataOutReady;
      unique case (state)
         RxIdle: begin
            if (rxIn == StartBit) begin
               cntNext   = '0;
               stateNext = RxStart;
            end
         end
         RxStart: begin
            if (cnt == HalfEnd) begin
               cntNext    = '0;
               bitIdxNext = '0;
               stateNext  = (rxIn == StartBit) ? RxData : RxIdle;
            end else begin
               cntNext = cnt + CntW'(1);
            end
         end
         RxData: begin
            if (cnt == BitEnd) begin
               cntNext   = '0;
               shiftNext = (shift >> 1) | (Width'(rxIn) << (Width - 1));
               if (bitIdx == LastBit) stateNext = RxStop;
               else bitIdxNext = bitIdx + BitW'(1);
            end else begin
               cntNext = cnt + CntW'(1);
            end
         end
         RxStop: begin
            if (cnt == BitEnd) begin
               cntNext = '0;
               // Leaving at the stop-bit centre keeps the next start edge fully visible.
               if (rxIn == StopBit) begin
                  if (!DataOutValid || DataOutReady) begin
                     dataNext  = shift;
                     validNext = 1'b1;
                  end
                  stateNext = RxIdle;
               end else begin
                  stateNext = RxWaitHigh;
               end
            end else begin
               cntNext = cnt + CntW'(1);
            end
         end
         RxWaitHigh: begin
            if (rxIn == IdleLevel) stateNext = RxIdle;
         end
         default: stateNext = RxIdle;
      endcase
   end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1-style uart: inline transmitter plus the uart_rx receiver,
// bridging valid/ready byte streams to the serial pins.
module uart
   import uart_pkg::*;
#(
   parameter int unsigned ClockFreq = 200_000_000,
   parameter int unsigned Baud      = 115200,
   parameter int unsigned Width     = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] DataIn,
   input  logic             DataInValid,
   output logic             DataInReady,
   output logic [Width-1:0] DataOut,
   output logic             DataOutValid,
   input  logic             DataOutReady,
   input  logic             SIn,
   output logic             SOut
);

   localparam int unsigned     Divisor = ClockFreq / Baud;
   localparam int unsigned     CntW    = clog2(Divisor);
   localparam int unsigned     BitW    = clog2(Width);
   localparam logic [CntW-1:0] BitEnd  = CntW'(Divisor - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(Width - 1);

   if (Divisor < 4) begin : gDivisorCheck
      $error("uart: ClockFreq/Baud must be at least 4");
   end

   txState_t         txState, txStateNext;
   logic [CntW-1:0]  txCnt, txCntNext;
   logic [BitW-1:0]  txBit, txBitNext, txBitInc;
   logic [Width-1:0] txShift, txShiftNext;
   logic             sOutNext;

   assign DataInReady = (txState == TxIdle) && !Reset;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         txState <= TxIdle;
         txCnt   <= '0;
         txBit   <= '0;
         txShift <= '0;
         SOut    <= IdleLevel;
      end else begin
         txState <= txStateNext;
         txCnt   <= txCntNext;
         txBit   <= txBitNext;
         txShift <= txShiftNext;
         SOut    <= sOutNext;
      end
   end

   // The line level is registered, so each transition loads the level of the bit that follows it.
   always_comb begin
      txStateNext = txState;
      txCntNext   = txCnt;
      txBitNext   = txBit;
      txShiftNext = txShift;
      sOutNext    = SOut;
      txBitInc    = txBit + BitW'(1);
      unique case (txState)
         TxIdle: begin
            if (DataInValid) begin
               txShiftNext = DataIn;
               txCntNext   = '0;
               sOutNext    = StartBit;
               txStateNext = TxStart;
            end
         end
         TxStart: begin
            if (txCnt == BitEnd) begin
               txCntNext   = '0;
               txBitNext   = '0;
               sOutNext    = txShift[0];
               txStateNext = TxData;
            end else begin
               txCntNext = txCnt + CntW'(1);
            end
         end
         TxData: begin
            if (txCnt == BitEnd) begin
               txCntNext = '0;
               if (txBit == LastBit) begin
                  sOutNext    = StopBit;
                  txStateNext = TxStop;
               end else begin
                  txBitNext = txBitInc;
                  sOutNext  = txShift[txBitInc];
               end
            end else begin
               txCntNext = txCnt + CntW'(1);
            end
         end
         TxStop: begin
            if (txCnt == BitEnd) begin
               txCntNext   = '0;
               txStateNext = TxIdle;
            end else begin
               txCntNext = txCnt + CntW'(1);
            end
         end
         default: txStateNext = TxIdle;
      endcase
   end

   uart_rx #(
      .Divisor(Divisor),
      .Width  (Width)
   ) rx (
      .Clock       (Clock),
      .Reset       (Reset),
      .SIn         (SIn),
      .DataOut     (DataOut),
      .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady)
   );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: frame-level reference model of the serial line
// and byte queues for delivery order, with randomized bytes.
module tb_uart;

   localparam int unsigned ClockFreq = 1_600_000;
   localparam int unsigned Baud      = 100_000;
   localparam int          Div       = 16;
   localparam int          FrameCyc  = 10 * Div;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] DataIn = '0;
   logic       DataInValid = 1'b0;
   logic       DataInReady;
   logic [7:0] DataOut;
   logic       DataOutValid;
   logic       DataOutReady = 1'b0;
   logic       SIn;
   logic       SOut;
   logic       tbSIn = 1'b1;
   logic       loopback = 1'b0;

   int tests = 0;
   int fails = 0;

   assign SIn = loopback ? SOut : tbSIn;

   always #5 Clock = ~Clock;

   uart #(
      .ClockFreq(ClockFreq),
      .Baud     (Baud),
      .Width    (8)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .DataIn      (DataIn),
      .DataInValid (DataInValid),
      .DataInReady (DataInReady),
      .DataOut     (DataOut),
      .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady),
      .SIn         (SIn),
      .SOut        (SOut)
   );

   // Line level k cycles into a frame: slot 0 start, slots 1..8 data LSB first, slot 9 stop.
   function automatic logic frameLevel(input logic [7:0] b, input int k);
      int slot;
      slot = k / Div;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   task automatic sendTx(input logic [7:0] b, output int bad, output int readyLow, output bit timedOut);
      int waited;
      waited = 0;
      bad = 0;
      readyLow = 0;
      timedOut = 0;
      while (DataInReady !== 1'b1 && waited < 4 * FrameCyc) begin
         @(negedge Clock);
         waited++;
      end
      if (DataInReady !== 1'b1) timedOut = 1;
      DataIn = b;
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      for (int k = 0; k < FrameCyc; k++) begin
         if (SOut !== frameLevel(b, k)) bad++;
         if (DataInReady !== 1'b1) readyLow++;
         DataIn = 8'($urandom);
         @(negedge Clock);
      end
      waited = 0;
      while (DataInReady !== 1'b1 && waited < FrameCyc) begin
         readyLow++;
         waited++;
         @(negedge Clock);
      end
   endtask

   task automatic sendSerial(input logic [7:0] b, input logic stopLvl);
      for (int k = 0; k < FrameCyc; k++) begin
         tbSIn = (k / Div == 9) ? stopLvl : frameLevel(b, k);
         @(negedge Clock);
      end
      tbSIn = 1'b1;
   endtask

   task automatic consume();
      DataOutReady = 1'b1;
      @(negedge Clock);
      DataOutReady = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clock);
      tests++; if (SOut !== 1'b1) begin fails++; $display("FAIL reset_sout: got %b expected 1", SOut); end
      tests++; if (DataInReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", DataInReady); end
      tests++; if (DataOutValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", DataOutValid); end
      tests++; if (DataOut !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", DataOut); end
      Reset = 1'b0;
      @(negedge Clock);
      tests++; if (DataInReady !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", DataInReady); end
   endtask

   task automatic test_tx_frame();
      logic [7:0] b;
      int bad, readyLow;
      bit to;
      for (int i = 0; i < 4; i++) begin
         b = (i == 0) ? 8'hA5 : 8'($urandom);
         sendTx(b, bad, readyLow, to);
         tests++; if (to) begin fails++; $display("FAIL tx_ready_timeout: byte %h never accepted", b); end
         tests++; if (bad != 0) begin fails++; $display("FAIL tx_wave: byte %h got %0d bad cycles expected 0", b, bad); end
         tests++; if (readyLow != FrameCyc) begin fails++; $display("FAIL tx_ready_low: got %0d cycles expected %0d", readyLow, FrameCyc); end
         tests++; if (SOut !== 1'b1) begin fails++; $display("FAIL tx_idle_level: got %b expected 1", SOut); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      logic [7:0] got[$];
      logic       expWave[$];
      int n, idx, bad, accepts, len;
      bit willAccept;
      logic expLvl;
      n = 4; idx = 0; bad = 0; accepts = 0;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < FrameCyc; k++) expWave.push_back(frameLevel(q[i], k));
         expWave.push_back(1'b1);
      end
      len = expWave.size() + Div;
      loopback = 1'b1;
      DataOutReady = 1'b1;
      DataIn = q[0];
      DataInValid = 1'b1;
      willAccept = (DataInReady === 1'b1);
      for (int c = 0; c < len; c++) begin
         @(negedge Clock);
         if (willAccept) begin
            accepts++;
            idx++;
            if (idx < n) DataIn = q[idx];
            else DataInValid = 1'b0;
         end
         expLvl = (c < expWave.size()) ? expWave[c] : 1'b1;
         if (SOut !== expLvl) bad++;
         if (DataOutValid === 1'b1) got.push_back(DataOut);
         willAccept = (DataInReady === 1'b1) && DataInValid;
      end
      DataInValid = 1'b0;
      DataOutReady = 1'b0;
      loopback = 1'b0;
      tests++; if (bad != 0) begin fails++; $display("FAIL b2b_wave: got %0d bad cycles expected 0", bad); end
      tests++; if (accepts != n) begin fails++; $display("FAIL b2b_accepts: got %0d expected %0d", accepts, n); end
      tests++; if (got.size() != n) begin fails++; $display("FAIL b2b_rx_count: got %0d expected %0d", got.size(), n); end
      for (int i = 0; i < n && i < got.size(); i++) begin
         tests++; if (got[i] !== q[i]) begin fails++; $display("FAIL b2b_rx_byte%0d: got %h expected %h", i, got[i], q[i]); end
      end
      repeat (2) @(negedge Clock);
   endtask

   task automatic test_rx_hold();
      logic [7:0] b;
      int bad;
      b = 8'h3C;
      bad = 0;
      sendSerial(b, 1'b1);
      tests++; if (DataOutValid !== 1'b1) begin fails++; $display("FAIL rx_valid: got %b expected 1", DataOutValid); end
      tests++; if (DataOut !== b) begin fails++; $display("FAIL rx_data: got %h expected %h", DataOut, b); end
      repeat (3 * Div) begin
         @(negedge Clock);
         if (DataOutValid !== 1'b1 || DataOut !== b) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL rx_hold: got %0d bad cycles expected 0", bad); end
      consume();
      tests++; if (DataOutValid !== 1'b0) begin fails++; $display("FAIL rx_clear: got %b expected 0", DataOutValid); end
      b = 8'($urandom);
      sendSerial(b, 1'b1);
      tests++; if (DataOut !== b || DataOutValid !== 1'b1) begin fails++; $display("FAIL rx_random: got %h/%b expected %h/1", DataOut, DataOutValid, b); end
      consume();
   endtask

   task automatic test_glitch();
      int seen;
      seen = 0;
      tbSIn = 1'b0;
      repeat (Div / 4) @(negedge Clock);
      tbSIn = 1'b1;
      repeat (2 * Div) begin
         @(negedge Clock);
         if (DataOutValid !== 1'b0) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", seen); end
      sendSerial(8'h55, 1'b1);
      tests++; if (DataOut !== 8'h55 || DataOutValid !== 1'b1) begin fails++; $display("FAIL glitch_next: got %h/%b expected 55/1", DataOut, DataOutValid); end
      consume();
   endtask

   task automatic test_framing();
      int seen;
      seen = 0;
      sendSerial(8'($urandom), 1'b0);
      repeat (Div) begin
         @(negedge Clock);
         if (DataOutValid !== 1'b0) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL framing_drop: got %0d valid cycles expected 0", seen); end
      sendSerial(8'h81, 1'b1);
      tests++; if (DataOut !== 8'h81 || DataOutValid !== 1'b1) begin fails++; $display("FAIL framing_next: got %h/%b expected 81/1", DataOut, DataOutValid); end
      consume();
   endtask

   task automatic test_overrun();
      logic [7:0] a, b;
      int seen;
      a = 8'($urandom);
      b = ~a;
      seen = 0;
      sendSerial(a, 1'b1);
      sendSerial(b, 1'b1);
      tests++; if (DataOut !== a || DataOutValid !== 1'b1) begin fails++; $display("FAIL overrun_keep: got %h/%b expected %h/1", DataOut, DataOutValid, a); end
      consume();
      repeat (2 * Div) begin
         if (DataOutValid !== 1'b0) seen++;
         @(negedge Clock);
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL overrun_drop: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b, nb;
      int bad, readyLow;
      bit to;
      b = 8'($urandom);
      nb = 8'($urandom);
      loopback = 1'b1;
      DataIn = b;
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      repeat ($urandom_range(8 * Div, Div)) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      tests++; if (SOut !== 1'b1) begin fails++; $display("FAIL midreset_sout: got %b expected 1", SOut); end
      tests++; if (DataInReady !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b expected 0", DataInReady); end
      repeat (2) @(negedge Clock);
      tests++; if (DataInReady !== 1'b0 || DataOutValid !== 1'b0) begin fails++; $display("FAIL midreset_hold: got ready %b valid %b expected 0 0", DataInReady, DataOutValid); end
      Reset = 1'b0;
      @(negedge Clock);
      tests++; if (DataInReady !== 1'b1) begin fails++; $display("FAIL midreset_release: got %b expected 1", DataInReady); end
      sendTx(nb, bad, readyLow, to);
      tests++; if (to || bad != 0) begin fails++; $display("FAIL midreset_tx_wave: got %0d bad cycles timeout %b expected 0 0", bad, to); end
      tests++; if (DataOut !== nb || DataOutValid !== 1'b1) begin fails++; $display("FAIL midreset_rx: got %h/%b expected %h/1", DataOut, DataOutValid, nb); end
      consume();
      tests++; if (DataOutValid !== 1'b0) begin fails++; $display("FAIL midreset_clear: got %b expected 0", DataOutValid); end
      loopback = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_back_to_back();
      test_rx_hold();
      test_glitch();
      test_framing();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
